// File: rtl/wb_unit_pkg.sv
// Shared types for the writeback stage: result-source encodings, load
// funct3 constants and the writeback FSM state enum.
package wb_pkg;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_ALU   = 3'd1,
    SEL_IMM   = 3'd2,
    SEL_PC    = 3'd3,
    SEL_PCSEQ = 3'd4,
    SEL_CSR   = 3'd5,
    SEL_LOAD  = 3'd6
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// Writeback-stage bus: execute handshake, load response, GPR write port,
// retire/hazard status. master = surrounding pipeline, slave = wb_unit.
interface wb_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_sel;
  logic [XLEN-1:0] ex_alu;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_pcseq;
  logic [XLEN-1:0] ex_csr;
  logic [2:0]      ex_funct3;
  logic [1:0]      ex_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rready;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            retire;
  logic            pend_valid;
  logic [4:0]      pend_rd;
  logic            err;

  modport master (
    output ex_valid, ex_rd, ex_sel, ex_alu, ex_imm, ex_pc, ex_pcseq, ex_csr,
           ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
    input  ex_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, retire,
           pend_valid, pend_rd, err
  );

  modport slave (
    input  ex_valid, ex_rd, ex_sel, ex_alu, ex_imm, ex_pc, ex_pcseq, ex_csr,
           ex_funct3, ex_addr_lo, mem_rvalid, mem_rdata,
    output ex_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, retire,
           pend_valid, pend_rd, err
  );
endinterface

// File: rtl/wb_unit_load_ext.sv
// Load data alignment and sign/zero extension (combinational).
module load_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] ext
);

  logic [1:0]      off;
  logic [XLEN-1:0] sh;

  always_comb begin
    off = '0;
    case (funct3)
      F3_LB, F3_LBU: off = addr_lo;
      F3_LH, F3_LHU: off = {addr_lo[1], 1'b0};
      default:       off = '0;
    endcase
    sh = mem_rdata >> {off, 3'b000};
  end

  always_comb begin
    ext = mem_rdata;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LH:   ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: sole writer of the GPR write port, with load wait state.
// Optional load-response timeout enabled by `define WB_LOAD_TIMEOUT_EN.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic      clk,
  input  logic      rst,
  wb_unit_if.slave  bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_unit: TIMEOUT must be at least 1");
  end

  wb_state_e       state;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_alo;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] sel_data;
  logic            sel_writes;
  logic            err_q;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .mem_rdata (bus.mem_rdata),
    .funct3    (ld_f3),
    .addr_lo   (ld_alo),
    .ext       (ld_data)
  );

  always_comb begin
    sel_data   = '0;
    sel_writes = 1'b1;
    case (wb_sel_e'(bus.ex_sel))
      SEL_ALU:   sel_data = bus.ex_alu;
      SEL_IMM:   sel_data = bus.ex_imm;
      SEL_PC:    sel_data = bus.ex_pc;
      SEL_PCSEQ: sel_data = bus.ex_pcseq;
      SEL_CSR:   sel_data = bus.ex_csr;
      default:   sel_writes = 1'b0;
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.retire   <= 1'b0;
      err_q        <= 1'b0;
      ld_rd        <= '0;
      ld_f3        <= '0;
      ld_alo       <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      bus.rf_wen <= 1'b0;
      bus.retire <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ex_valid) begin
            if (wb_sel_e'(bus.ex_sel) == SEL_LOAD) begin
              ld_rd  <= bus.ex_rd;
              ld_f3  <= bus.ex_funct3;
              ld_alo <= bus.ex_addr_lo;
              state  <= ST_WAIT_MEM;
`ifdef WB_LOAD_TIMEOUT_EN
              cnt    <= '0;
`endif
            end else begin
              bus.rf_wen   <= sel_writes && (bus.ex_rd != 5'd0);
              bus.rf_waddr <= bus.ex_rd;
              bus.rf_wdata <= sel_data;
              bus.retire   <= 1'b1;
            end
          end
        end
        ST_WAIT_MEM: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (bus.mem_rvalid) begin
            bus.rf_wen   <= (ld_rd != 5'd0);
            bus.rf_waddr <= ld_rd;
            bus.rf_wdata <= ld_data;
            bus.retire   <= 1'b1;
            state        <= ST_IDLE;
          end
`ifdef WB_LOAD_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            bus.retire <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ex_ready   = (state == ST_IDLE);
  assign bus.mem_rready = (state == ST_WAIT_MEM);
  assign bus.pend_valid = (state == ST_WAIT_MEM);
  assign bus.pend_rd    = (state == ST_WAIT_MEM) ? ld_rd : 5'd0;

endmodule
